model_out_fifo: RTL and testbench

Elastic buffer directly downstream of the `model` cell. It captures `model`'s mixed-endian output buses `o0` [2:-2] and `o1` [-2:2] and normalises them into one MSB-first 10-bit word. Words are held in a small FIFO with valid/ready handshakes on both sides. Downstream logic therefore consumes `model` results without caring about negative or ascending index ranges.

---
 rtl/model_if_pkg.sv | 21 ++
 rtl/model_out_pack.sv | 20 ++
 rtl/model_out_fifo.sv | 91 +++++++++
 tb/tb_model_out_fifo.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/model_if_pkg.sv
// rtl/model_if_pkg.sv - shared index ranges, word type and packing function for the model output buses
package model_if_pkg;

  localparam int O0_MSB   = 2;
  localparam int O0_LSB   = -2;
  localparam int O1_LEFT  = -2;
  localparam int O1_RIGHT = 2;
  localparam int PACKED_W = 10;

  typedef logic [PACKED_W-1:0] model_word_t;

  // Concatenation keeps declaration order: leftmost bit of o0 lands in bit 9,
  // rightmost bit of o1 in bit 0, whatever the direction of each range.
  function automatic model_word_t pack_model_out(
    input logic [O0_MSB:O0_LSB]    o0,
    input logic [O1_LEFT:O1_RIGHT] o1
  );
    return {o0, o1};
  endfunction

endpackage

// File: rtl/model_out_pack.sv
// rtl/model_out_pack.sv - combinational remap of o0/o1 into one MSB-first word, parity with MODEL_OUT_FIFO_PARITY_EN
module model_out_pack
  import model_if_pkg::*;
(
  input  logic [O0_MSB:O0_LSB]    o0_i,
  input  logic [O1_LEFT:O1_RIGHT] o1_i,
  output model_word_t             word_o
`ifdef MODEL_OUT_FIFO_PARITY_EN
  ,
  output logic                    par_o
`endif
);

  assign word_o = pack_model_out(o0_i, o1_i);

`ifdef MODEL_OUT_FIFO_PARITY_EN
  assign par_o = ^word_o;
`endif

endmodule

// File: rtl/model_out_fifo.sv
// rtl/model_out_fifo.sv - elastic FIFO for packed model outputs, optional parity with MODEL_OUT_FIFO_PARITY_EN
module model_out_fifo
  import model_if_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [O0_MSB:O0_LSB]    o0_in,
  input  logic [O1_LEFT:O1_RIGHT] o1_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output model_word_t             out_data,
  output logic                    out_par,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [AW:0]             level
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wp_q, wp_d;
  logic [AW:0] rp_q, rp_d;
  model_word_t mem_q [DEPTH];
  model_word_t pack_word;
  logic        full, empty, push, pop;

`ifdef MODEL_OUT_FIFO_PARITY_EN
  logic pack_par;
  logic par_q [DEPTH];

  model_out_pack u_pack (
    .o0_i   (o0_in),
    .o1_i   (o1_in),
    .word_o (pack_word),
    .par_o  (pack_par)
  );
`else
  model_out_pack u_pack (
    .o0_i   (o0_in),
    .o1_i   (o1_in),
    .word_o (pack_word)
  );
`endif

  // Wrap bit distinguishes full from empty when the address bits match.
  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign level     = wp_q - rp_q;
  assign out_data  = mem_q[rp_q[AW-1:0]];

`ifdef MODEL_OUT_FIFO_PARITY_EN
  assign out_par = empty ? 1'b0 : par_q[rp_q[AW-1:0]];
`else
  assign out_par = 1'b0;
`endif

  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (push) wp_d = wp_q + PTR_ONE;
    if (pop)  rp_d = rp_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  // Entry storage is deliberately left out of reset; only the pointers matter.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wp_q[AW-1:0]] <= pack_word;
`ifdef MODEL_OUT_FIFO_PARITY_EN
      par_q[wp_q[AW-1:0]] <= pack_par;
`endif
    end
  end

endmodule

// File: tb/tb_model_out_fifo.sv
// tb/tb_model_out_fifo.sv - self-checking bench for model_out_fifo with a queue reference model
module tb_model_out_fifo;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [2:-2]     o0_in;
  logic [-2:2]     o1_in;
  logic            in_valid;
  logic            in_ready;
  logic [9:0]      out_data;
  logic            out_par;
  logic            out_valid;
  logic            out_ready;
  logic [AW:0]     level;

  int n_checks = 0;
  int n_fail   = 0;
  logic [9:0] q[$];

  always #5 clk = ~clk;

  model_out_fifo #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .o0_in     (o0_in),
    .o1_in     (o1_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_par   (out_par),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level)
  );

  function automatic logic [9:0] ref_pack(input logic [2:-2] a, input logic [-2:2] b);
    logic [9:0] w;
    for (int i = -2; i <= 2; i++) begin
      w[7 + i] = a[i];
      w[2 - i] = b[i];
    end
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy queue, pop before push, cleared by reset.
  always @(negedge rst_n) q.delete();

  always @(posedge clk) begin
    if (rst_n) begin
      bit do_push, do_pop;
      do_push = in_valid && (q.size() < DEPTH);
      do_pop  = out_ready && (q.size() > 0);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(ref_pack(o0_in, o1_in));
    end
  end

  always @(negedge clk) begin
    check("m_in_ready", in_ready, q.size() < DEPTH);
    check("m_out_valid", out_valid, q.size() != 0);
    check("m_level", level, q.size());
    if (q.size() != 0) check("m_out_data", out_data, q[0]);
`ifdef MODEL_OUT_FIFO_PARITY_EN
    check("m_out_par", out_par, (q.size() != 0) ? ^q[0] : 1'b0);
`else
    check("m_out_par", out_par, 0);
`endif
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_word(input logic [9:0] w);
    o0_in = w[9:5];
    o1_in = w[4:0];
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] fill_w [4];
    fill_w[0] = 10'h001; fill_w[1] = 10'h002; fill_w[2] = 10'h004; fill_w[3] = 10'h008;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    o0_in = '0; o1_in = '0;
    cyc(); cyc();
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_level", level, 0);
    check("rst_out_par", out_par, 0);

    // packing order
    o0_in = 5'b10000; o1_in = 5'b10000; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    check("pack_valid", out_valid, 1);
    check("pack_data", out_data, 10'h210);
    out_ready = 1'b1; cyc(); out_ready = 1'b0;
    check("pack_drained", level, 0);

    // fill to full
    for (int i = 0; i < 4; i++) begin
      drive_word(fill_w[i]); in_valid = 1'b1; cyc();
    end
    check("fill_level", level, 4);
    check("fill_in_ready", in_ready, 0);
    drive_word(10'h010); cyc();
    in_valid = 1'b0;
    check("fill_5th_rejected", level, 4);
    for (int i = 0; i < 4; i++) begin
      check("drain_order", out_data, fill_w[i]);
      out_ready = 1'b1; cyc();
    end
    out_ready = 1'b0;
    check("drain_empty", out_valid, 0);

    // full with simultaneous push and pop
    for (int i = 0; i < 4; i++) begin
      drive_word(10'h011 + 10'(i)); in_valid = 1'b1; cyc();
    end
    drive_word(10'h0AA); in_valid = 1'b1; out_ready = 1'b1;
    cyc();
    check("full_pop_only", level, 3);
    check("full_ready_back", in_ready, 1);
    cyc();
    in_valid = 1'b0;
    check("full_push_pop", level, 3);
    check("full_head", out_data, 10'h013);
    cyc(); cyc(); cyc();
    check("full_last", level, 0);

    // streaming across pointer wrap
    for (int i = 0; i < 20; i++) begin
      drive_word(10'(i)); in_valid = 1'b1; cyc();
      check("stream_level", level, 1);
      check("stream_data", out_data, i);
    end
    in_valid = 1'b0; cyc();
    out_ready = 1'b0;
    check("stream_end", level, 0);

`ifdef MODEL_OUT_FIFO_PARITY_EN
    drive_word(10'h3FF); in_valid = 1'b1; cyc();
    check("par_3ff", out_par, 0);
    drive_word(10'h001); out_ready = 1'b1; cyc();
    check("par_001", out_par, 1);
    in_valid = 1'b0; cyc();
    out_ready = 1'b0;
    check("par_empty", out_par, 0);
`endif

    // reset mid-stream
    for (int i = 0; i < 3; i++) begin
      drive_word(10'h100 + 10'(i)); in_valid = 1'b1; cyc();
    end
    in_valid = 1'b0;
    check("mid_level", level, 3);
    rst_n = 1'b0;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_level", level, 0);
    check("async_in_ready", in_ready, 1);
    cyc();
    rst_n = 1'b1;
    drive_word(10'h155); in_valid = 1'b1; cyc();
    in_valid = 1'b0;
    check("post_rst_data", out_data, 10'h155);
    check("post_rst_level", level, 1);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
